// File: rtl/inst_pair_queue.sv
// Instruction issue queue: buffers fetched words with their PCs and presents an
// in-order first/second pair to dual-issue decode. Optional macro ISSUE_ALIGN_EN.
module inst_pair_queue #(
  parameter int DEPTH   = 16,
  parameter int FETCH_W = 4,
  parameter int PC_W    = 15
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_flush,
  input  logic                         i_fill_valid,
  output logic                         o_fill_ready,
  input  logic [32*FETCH_W-1:0]        i_fill_data,
  input  logic [PC_W-1:0]              i_fill_pc,
  input  logic [$clog2(FETCH_W):0]     i_fill_count,
  input  logic                         i_issue_ready,
  output logic                         o_first_valid,
  output logic                         o_second_valid,
  output logic [31:0]                  o_first_inst,
  output logic [31:0]                  o_second_inst,
  output logic [PC_W-1:0]              o_first_pc,
  output logic [$clog2(DEPTH):0]       o_occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int CW = $clog2(FETCH_W) + 1;
  localparam logic [OW-1:0] FILL_LIMIT = OW'(DEPTH - FETCH_W);
  localparam logic [31:0]   NOP_WORD   = 32'h4020_0000;
  localparam logic [31:0]   LNOP_WORD  = 32'h0020_0000;

  logic [31:0]     r_word [DEPTH];
  logic [PC_W-1:0] r_pc   [DEPTH];
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [OW-1:0]   r_occ;

  logic [AW-1:0]   w_head_nxt_idx;
  logic [PC_W-1:0] w_head_pc;
  logic [PC_W-1:0] w_next_pc;
  logic [PC_W:0]   w_head_pc_plus4;
  logic            w_contig;
  logic            w_align_ok;
  logic            w_first_valid;
  logic            w_second_valid;
  logic [1:0]      w_pop;
  logic            w_fill_ready;
  logic            w_fill_acc;
  logic [OW-1:0]   w_fill_n;

  logic [AW-1:0]   w_wr_idx  [FETCH_W];
  logic [PC_W-1:0] w_wr_pc   [FETCH_W];
  logic [31:0]     w_wr_word [FETCH_W];
  logic            w_wr_en   [FETCH_W];

  assign w_head_nxt_idx = r_head + AW'(1);
  assign w_head_pc      = r_pc[r_head];
  assign w_next_pc      = r_pc[w_head_nxt_idx];

  // One extra bit so a pair straddling the PC wrap point never looks contiguous.
  assign w_head_pc_plus4 = {1'b0, w_head_pc} + (PC_W+1)'(4);
  assign w_contig        = (w_head_pc_plus4 == {1'b0, w_next_pc});

`ifdef ISSUE_ALIGN_EN
  assign w_align_ok = ~w_head_pc[2];
`else
  assign w_align_ok = 1'b1;
`endif

  assign w_first_valid  = (r_occ != '0);
  assign w_second_valid = (r_occ >= OW'(2)) && w_contig && w_align_ok;
  assign w_pop          = i_issue_ready ? ({1'b0, w_first_valid} + {1'b0, w_second_valid}) : 2'd0;

  assign w_fill_ready = (r_occ <= FILL_LIMIT);
  assign w_fill_acc   = i_fill_valid && w_fill_ready;
  assign w_fill_n     = w_fill_acc ? OW'(i_fill_count) : '0;

  genvar gi;
  generate
    for (gi = 0; gi < FETCH_W; gi++) begin : g_lane
      assign w_wr_idx[gi]  = r_tail + AW'(gi);
      assign w_wr_pc[gi]   = i_fill_pc + PC_W'(4 * gi);
      assign w_wr_word[gi] = i_fill_data[32*(FETCH_W-gi)-1 -: 32];
      assign w_wr_en[gi]   = w_fill_acc && !i_flush && !i_reset && (i_fill_count > CW'(gi));
    end
  endgenerate

  always_ff @(posedge i_clock) begin
    for (int k = 0; k < FETCH_W; k++) begin
      if (w_wr_en[k]) begin
        r_word[w_wr_idx[k]] <= w_wr_word[k];
        r_pc[w_wr_idx[k]]   <= w_wr_pc[k];
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      r_head <= r_head + AW'(w_pop);
      r_tail <= r_tail + AW'(w_fill_n);
      r_occ  <= r_occ + w_fill_n - OW'(w_pop);
    end
  end

  assign o_fill_ready   = w_fill_ready;
  assign o_first_valid  = w_first_valid;
  assign o_second_valid = w_second_valid;
  assign o_first_inst   = w_first_valid  ? r_word[r_head]         : NOP_WORD;
  assign o_second_inst  = w_second_valid ? r_word[w_head_nxt_idx] : LNOP_WORD;
  assign o_first_pc     = w_first_valid  ? w_head_pc              : '0;
  assign o_occupancy    = r_occ;

  a_fill_count_legal: assert property (@(posedge i_clock) disable iff (i_reset)
    (i_fill_valid && w_fill_ready) |-> (i_fill_count != '0 && i_fill_count <= CW'(FETCH_W)));

endmodule

// File: tb/tb_inst_pair_queue.sv
// Directed self-checking bench for inst_pair_queue (default parameters).
module tb_inst_pair_queue;

  localparam int DEPTH   = 16;
  localparam int FETCH_W = 4;
  localparam int PC_W    = 15;
  localparam logic [31:0] NOP  = 32'h4020_0000;
  localparam logic [31:0] LNOP = 32'h0020_0000;
  localparam logic [31:0] IL1  = 32'h4080_0501;
  localparam logic [31:0] IL2  = 32'h4080_0A02;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             fill_valid;
  logic             fill_ready;
  logic [127:0]     fill_data;
  logic [PC_W-1:0]  fill_pc;
  logic [2:0]       fill_count;
  logic             issue_ready;
  logic             first_valid;
  logic             second_valid;
  logic [31:0]      first_inst;
  logic [31:0]      second_inst;
  logic [PC_W-1:0]  first_pc;
  logic [4:0]       occupancy;

  int n_checks = 0;
  int n_errors = 0;

  inst_pair_queue #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .PC_W(PC_W)) dut (
    .i_clock        (clk),
    .i_reset        (reset),
    .i_flush        (flush),
    .i_fill_valid   (fill_valid),
    .o_fill_ready   (fill_ready),
    .i_fill_data    (fill_data),
    .i_fill_pc      (fill_pc),
    .i_fill_count   (fill_count),
    .i_issue_ready  (issue_ready),
    .o_first_valid  (first_valid),
    .o_second_valid (second_valid),
    .o_first_inst   (first_inst),
    .o_second_inst  (second_inst),
    .o_first_pc     (first_pc),
    .o_occupancy    (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic check_state(input string tag, input logic fv, input logic sv,
                             input logic [31:0] fi, input logic [31:0] si,
                             input logic [PC_W-1:0] fpc, input logic [4:0] occ);
    check({tag, ".first_valid"},  64'(first_valid),  64'(fv));
    check({tag, ".second_valid"}, 64'(second_valid), 64'(sv));
    check({tag, ".first_inst"},   64'(first_inst),   64'(fi));
    check({tag, ".second_inst"},  64'(second_inst),  64'(si));
    check({tag, ".first_pc"},     64'(first_pc),     64'(fpc));
    check({tag, ".occupancy"},    64'(occupancy),    64'(occ));
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fill(input logic v, input logic [PC_W-1:0] pc, input logic [2:0] cnt,
                          input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3);
    fill_valid = v;
    fill_pc    = pc;
    fill_count = cnt;
    fill_data  = {w0, w1, w2, w3};
  endtask

  function automatic logic [31:0] wv(input int pc);
    return 32'hA000_0000 | 32'(pc);
  endfunction

  int exp_pc  [10] = '{'h08, 'h10, 'h18, 'h20, 'h28, 'h30, 'h38, 'h40, 'h48, 0};
  int exp_occ [10] = '{14, 12, 14, 12, 10, 8, 6, 4, 2, 0};

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    issue_ready = 1'b0;
    set_fill(1'b0, '0, 3'd1, 0, 0, 0, 0);
    step();
    step();
    check_state("rst", 0, 0, NOP, LNOP, 0, 0);
    check("rst.fill_ready", 64'(fill_ready), 64'd1);
    reset = 1'b0;

    // basic pair issue
    set_fill(1'b1, 15'h100, 3'd4, IL1, LNOP, IL2, LNOP);
    issue_ready = 1'b1;
    step();
    fill_valid = 1'b0;
    check_state("t1a", 1, 1, IL1, LNOP, 15'h100, 4);
    step();
    check_state("t1b", 1, 1, IL2, LNOP, 15'h108, 2);
    step();
    check_state("t1c", 0, 0, NOP, LNOP, 0, 0);
    issue_ready = 1'b0;

    // fill to full, hold a beat while full, then drain with pointer wrap
    for (int i = 0; i < 4; i++) begin
      set_fill(1'b1, 15'(i*16), 3'd4, wv(i*16), wv(i*16+4), wv(i*16+8), wv(i*16+12));
      step();
      if (i == 2) begin
        check("t2.occ12", 64'(occupancy), 64'd12);
        check("t2.ready12", 64'(fill_ready), 64'd1);
      end
    end
    check("t2.occ16", 64'(occupancy), 64'd16);
    check("t2.ready16", 64'(fill_ready), 64'd0);
    set_fill(1'b1, 15'h40, 3'd4, wv('h40), wv('h44), wv('h48), wv('h4C));
    step();
    check("t2.hold_occ", 64'(occupancy), 64'd16);
    check("t2.hold_ready", 64'(fill_ready), 64'd0);
    check("t2.hold_pc", 64'(first_pc), 64'd0);
    issue_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 2) fill_valid = 1'b0;
      check($sformatf("t2.drain%0d.pc", i),    64'(first_pc),     64'(exp_pc[i]));
      check($sformatf("t2.drain%0d.occ", i),   64'(occupancy),    64'(exp_occ[i]));
      check($sformatf("t2.drain%0d.ready", i), 64'(fill_ready),   64'(exp_occ[i] <= 12));
      check($sformatf("t2.drain%0d.sv", i),    64'(second_valid), 64'(exp_occ[i] >= 2));
      check($sformatf("t2.drain%0d.inst", i),  64'(first_inst),
            64'((exp_occ[i] != 0) ? wv(exp_pc[i]) : NOP));
    end
    issue_ready = 1'b0;

    // misaligned start
    set_fill(1'b1, 15'h104, 3'd3, 32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'h0);
    issue_ready = 1'b1;
    step();
    fill_valid = 1'b0;
`ifdef ISSUE_ALIGN_EN
    check_state("t3a", 1, 0, 32'hC000_0000, LNOP, 15'h104, 3);
    step();
    check_state("t3b", 1, 1, 32'hC000_0001, 32'hC000_0002, 15'h108, 2);
`else
    check_state("t3a", 1, 1, 32'hC000_0000, 32'hC000_0001, 15'h104, 3);
    step();
    check_state("t3b", 1, 0, 32'hC000_0002, LNOP, 15'h10C, 1);
`endif
    step();
    check_state("t3c", 0, 0, NOP, LNOP, 0, 0);
    issue_ready = 1'b0;

    // flush drops same-cycle fill
    set_fill(1'b1, 15'h200, 3'd2, 32'hD000_0000, 32'hD000_0001, 0, 0);
    step();
    check("t4.pre_pc", 64'(first_pc), 64'h200);
    check("t4.pre_occ", 64'(occupancy), 64'd2);
    flush = 1'b1;
    set_fill(1'b1, 15'h400, 3'd2, 32'hE000_0000, 32'hE000_0001, 0, 0);
    step();
    flush = 1'b0;
    check_state("t4.flush", 0, 0, NOP, LNOP, 0, 0);
    step();
    fill_valid = 1'b0;
    check_state("t4.post", 1, 1, 32'hE000_0000, 32'hE000_0001, 15'h400, 2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t4.clear_occ", 64'(occupancy), 64'd0);

    // non-contiguous words single-issue
    set_fill(1'b1, 15'h300, 3'd1, 32'hF000_0300, 0, 0, 0);
    step();
    set_fill(1'b1, 15'h500, 3'd1, 32'hF000_0500, 0, 0, 0);
    step();
    fill_valid = 1'b0;
    check_state("t5a", 1, 0, 32'hF000_0300, LNOP, 15'h300, 2);
    issue_ready = 1'b1;
    step();
    check_state("t5b", 1, 0, 32'hF000_0500, LNOP, 15'h500, 1);
    step();
    check_state("t5c", 0, 0, NOP, LNOP, 0, 0);
    issue_ready = 1'b0;

    // PC wrap is not contiguous
    set_fill(1'b1, 15'h7FFC, 3'd2, 32'h1111_1111, 32'h2222_2222, 0, 0);
    step();
    fill_valid = 1'b0;
    check_state("t6", 1, 0, 32'h1111_1111, LNOP, 15'h7FFC, 2);
    flush = 1'b1;
    step();
    flush = 1'b0;

    // reset mid-stream
    set_fill(1'b1, 15'h600, 3'd4, wv('h600), wv('h604), wv('h608), wv('h60C));
    step();
    set_fill(1'b1, 15'h610, 3'd3, wv('h610), wv('h614), wv('h618), 0);
    step();
    check("t7.occ7", 64'(occupancy), 64'd7);
    check("t7.pc", 64'(first_pc), 64'h600);
    reset = 1'b1;
    set_fill(1'b1, 15'h700, 3'd4, wv('h700), wv('h704), wv('h708), wv('h70C));
    step();
    check_state("t7.rst", 0, 0, NOP, LNOP, 0, 0);
    check("t7.rst_ready", 64'(fill_ready), 64'd1);
    reset = 1'b0;
    fill_valid = 1'b0;
    step();
    check("t7.after_occ", 64'(occupancy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_pair_queue.md
# inst_pair_queue

Parametrised instruction issue queue between local-store fetch and the dual-issue decode stage of the Cell SPU-lite core. Accepts up to FETCH_W consecutive 32-bit instruction words per cycle, buffers them in a DEPTH-entry circular queue with per-word PC, and presents an in-order instruction pair (first/second) to decode each cycle. Supports decode back-pressure, whole-queue flush on branch redirect, and a PC-contiguity pairing rule.

## Interface
- DEPTH, 16, queue capacity in words; power of two, ≥ 2·FETCH_W
- FETCH_W, 4, max words per fill beat; 2 or 4
- PC_W, 15, byte-address width of PCs; bits [1:0] always 0
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- flush  in  1  discard all queued words (branch redirect)
- fill_valid  in  1  fill beat offered
- fill_ready  out  1  queue has ≥ FETCH_W free entries
- fill_data  in  32·FETCH_W  words; word 0 in the most significant 32 bits
- fill_pc  in  PC_W  byte address of word 0
- fill_count  in  $clog2(FETCH_W)+1  valid words in the beat, 1..FETCH_W, leading words
- issue_ready  in  1  decode accepts the presented pair this cycle
- first_valid  out  1  first_inst holds a real instruction
- second_valid  out  1  second_inst holds a real instruction
- first_inst  out  32  oldest word, or 32'h4020_0000 (nop) when invalid
- second_inst  out  32  next word, or 32'h0020_0000 (lnop) when invalid
- first_pc  out  PC_W  PC of first_inst; 0 when invalid
- occupancy  out  $clog2(DEPTH)+1  words held

## Operation
- Storage: DEPTH entries of {word, pc}; head/tail pointers wrap modulo DEPTH; occupancy register.
- Fill: accepted when fill_valid && fill_ready; writes fill_count words at tail, entry k gets pc fill_pc+4k; tail advances by fill_count. fill_count of 0 or > FETCH_W is illegal (assertion).
- first_valid = occupancy ≥ 1.
- second_valid = occupancy ≥ 2 and pc(head+1) == pc(head)+4 (plus the alignment rule when ISSUE_ALIGN_EN is defined).
- Issue: when issue_ready, pop first_valid+second_valid words (0, 1 or 2). issue_ready with queue empty is a no-op.
- Simultaneous fill and pop in one cycle: both apply; occupancy += fill_count − popped.
- fill_ready computed from the registered occupancy only (not from same-cycle pop).
- flush: head, tail, occupancy cleared next cycle; a same-cycle fill and pop are dropped. flush has priority over everything but reset.
- reset: identical to flush; all outputs at reset values next cycle.
- PC arithmetic wraps modulo 2^PC_W; a pair spanning wrap (pc max → 0) is not contiguous and single-issues.

## Timing
- Outputs are combinational from registered queue state; a word filled in cycle N is presentable in cycle N+1 at the earliest.
- Pop takes effect at the clock edge where issue_ready is sampled; next pair visible the following cycle, giving full throughput of 2 words/cycle.
- Reset values: fill_ready=1, first_valid=0, second_valid=0, first_inst=32'h4020_0000, second_inst=32'h0020_0000, first_pc=0, occupancy=0.
- Full boundary: occupancy > DEPTH−FETCH_W ⇒ fill_ready=0; fill_valid is held by the source, no data lost.
- Empty boundary: occupancy 1 ⇒ single issue; a word arriving that cycle pairs no earlier than next cycle.

## Configuration
- ISSUE_ALIGN_EN defined: second_valid additionally requires pc(head)[2]==0 (first word doubleword-aligned, SPU even/odd pairing); a head at an odd word single-issues.
- ISSUE_ALIGN_EN undefined: any two contiguous words pair regardless of alignment.

## Test plan
- Reset, then fill 4 words pc=0x100 (il r1,10; lnop; il r2,20; lnop), issue_ready=1 → cycle+1 pair pc 0x100, cycle+2 pair pc 0x108, then first_valid=0, first_inst=32'h4020_0000.
- Fill DEPTH words with issue_ready=0 → fill_ready drops once occupancy > DEPTH−FETCH_W, occupancy=DEPTH; release issue_ready → 2 words/cycle until empty, pointers wrap correctly.
- Fill pc=0x104, 3 words, issue_ready=1 → ISSUE_ALIGN_EN: single issue 0x104 then pair 0x108/0x10C; without macro: pair 0x104/0x108 then single 0x10C.
- Fill 2 words at 0x200, flush, fill 2 words at 0x400 same cycle as flush then next cycle → flush-cycle fill dropped; first_pc=0x400 after post-flush fill.
- Fill 1 word at 0x300 then 1 word at 0x500, no issue, then issue_ready → 0x300 single-issues (non-contiguous), then 0x500.
- Assert reset mid-stream with occupancy 7 and fill_valid=1 → next cycle occupancy=0, all outputs at reset values.
